// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access controller.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } dmem_state_e;

    localparam int DMEM_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Request/ack bus between the memory-stage controller and the multi-cycle data memory.
interface dmem_access_ctrl_if;

    logic        mem_req;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_wr,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_wr,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/register16.sv
// Enabled holding register with synchronous active-high reset.
module register16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/dmem_access_ctrl.sv
// Memory-stage controller: turns EXMEM load/store controls into a req/ack access and stalls
// the pipeline while it is outstanding; aborts on misalignment or after TIMEOUT wait cycles.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int TIMEOUT = DMEM_TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 EXMEM_IDEX_MemRead,
    input  logic                 EXMEM_IDEX_MemWrite,
    input  logic [15:0]          EXMEM_ALUResult,
    input  logic [15:0]          EXMEM_read2DataOut,
    input  logic                 EXMEM_IDEX_HALT,
    dmem_access_ctrl_if.master   mem,
    output logic                 Stall_DM,
    output logic [15:0]          MEM_rdata,
    output logic                 MEM_rdata_valid,
    output logic                 err_pulse,
    output logic                 err_sticky
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    dmem_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             wr_q, wr_d;
    logic [15:0]      rdata_q, rdata_d;
    logic             vld_q, vld_d;
    logic             err_pulse_q, err_pulse_d;
    logic             err_sticky_q, err_sticky_d;
    logic             load_en;
    logic             access;
    logic [15:0]      addr_q;
    logic [15:0]      wdata_q;

    assign access = (EXMEM_IDEX_MemRead | EXMEM_IDEX_MemWrite) & ~EXMEM_IDEX_HALT;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        rdata_d     = rdata_q;
        vld_d       = 1'b0;
        err_pulse_d = 1'b0;
        load_en     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (access) begin
                    if (EXMEM_ALUResult[0]) begin
                        err_pulse_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        load_en = 1'b1;
                        wr_d    = EXMEM_IDEX_MemWrite;
                        cnt_d   = '0;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // An ack on the last counted cycle still completes the access cleanly.
                if (mem.mem_ack) begin
                    if (!wr_q) begin
                        rdata_d = mem.mem_rdata;
                        vld_d   = 1'b1;
                    end
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_pulse_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        req_d        = (state_d == WAIT);
        err_sticky_d = err_sticky_q | err_pulse_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_q        <= 1'b0;
            wr_q         <= 1'b0;
            rdata_q      <= '0;
            vld_q        <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            wr_q         <= wr_d;
            rdata_q      <= rdata_d;
            vld_q        <= vld_d;
            err_pulse_q  <= err_pulse_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    register16 #(.WIDTH(16)) u_addr_reg (
        .clk  (clk),
        .rst  (rst),
        .en_i (load_en),
        .d_i  (EXMEM_ALUResult),
        .q_o  (addr_q)
    );

    register16 #(.WIDTH(16)) u_wdata_reg (
        .clk  (clk),
        .rst  (rst),
        .en_i (load_en),
        .d_i  (EXMEM_read2DataOut),
        .q_o  (wdata_q)
    );

    assign mem.mem_req   = req_q;
    assign mem.mem_wr    = wr_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    assign Stall_DM        = ((state_q == IDLE) && access) || (state_q == WAIT);
    assign MEM_rdata       = rdata_q;
    assign MEM_rdata_valid = vld_q;
    assign err_pulse       = err_pulse_q;
    assign err_sticky      = err_sticky_q;

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Memory-stage controller: the downstream end of the EXMEM pipeline register. It consumes the EXMEM memory-control outputs and runs a req/ack handshake with a multi-cycle data memory. It generates `Stall_DM`, which freezes EXMEM (and, through the hazard logic, the upstream stages) while an access is outstanding. It presents read data to MEMWB.

## Interface

Parameters:
- `TIMEOUT`, default 16: maximum number of WAIT cycles without `mem_ack` before the access is aborted with an error.

Ports:
- `clk`  in  1  system clock; one clock domain. Reset is synchronous and active-high.
- `rst`  in  1  synchronous, active-high reset.
- `EXMEM_IDEX_MemRead`  in  1  load in the MEM stage.
- `EXMEM_IDEX_MemWrite`  in  1  store in the MEM stage.
- `EXMEM_ALUResult`  in  16  byte address of the access.
- `EXMEM_read2DataOut`  in  16  store data.
- `EXMEM_IDEX_HALT`  in  1  HALT in the MEM stage; suppresses any access.
- `mem_req`  out  1  request to memory. Held until `mem_ack`.
- `mem_wr`  out  1  1 = write, 0 = read. Valid while `mem_req` is high.
- `mem_addr`  out  16  latched address. Stable while `mem_req` is high.
- `mem_wdata`  out  16  latched store data. Stable while `mem_req` is high.
- `mem_ack`  in  1  one-cycle completion pulse from memory.
- `mem_rdata`  in  16  read data. Valid in the `mem_ack` cycle.
- `Stall_DM`  out  1  freeze EXMEM and upstream stages.
- `MEM_rdata`  out  16  registered load result for MEMWB.
- `MEM_rdata_valid`  out  1  `MEM_rdata` is valid this cycle.
- `err_pulse`  out  1  one-cycle pulse: access aborted (misaligned or timeout).
- `err_sticky`  out  1  latched error flag. Cleared only by `rst`.

## Operation

Definitions:
- `access` = (`EXMEM_IDEX_MemRead` | `EXMEM_IDEX_MemWrite`) & ~`EXMEM_IDEX_HALT`.
- If `EXMEM_IDEX_MemRead` and `EXMEM_IDEX_MemWrite` are both high, the access is a write.

FSM, 3 states:
- **IDLE**
  - `access` & `EXMEM_ALUResult[0]`=0: latch address, write data and `mem_wr`; clear the timeout counter; go to WAIT.
  - `access` & `EXMEM_ALUResult[0]`=1: misaligned. Set the error flag; go to DONE; issue no request.
  - Otherwise stay in IDLE.
- **WAIT**
  - `mem_req`=1.
  - `mem_ack`: capture `mem_rdata` into `MEM_rdata` (reads only); go to DONE.
  - Otherwise, counter == `TIMEOUT`-1: set the error flag; go to DONE.
  - Otherwise increment the counter.
- **DONE**
  - Unconditionally go to IDLE.
  - EXMEM still presents the same instruction in this cycle; DONE guarantees it is not re-issued.

Output rules:
- `Stall_DM` = (IDLE & `access`) | WAIT. Combinational; low in DONE.
- `MEM_rdata_valid` = DONE & read & no error.
- `err_pulse` = DONE & error. `err_sticky` sets on the same edge that enters DONE with an error.
- `mem_req`, `mem_wr`, `mem_addr`, `mem_wdata` are driven from registers only. No combinational path from EXMEM to memory.
- `MEM_rdata` holds its last value until the next successful read.

Boundary conditions:
- `mem_ack` in IDLE or DONE: ignored. `mem_rdata` is not captured.
- `mem_ack` in the same cycle the counter reaches `TIMEOUT`-1: the ack wins; no error.
- `rst` in any state: next state IDLE. `mem_req`=0 on the following cycle. A late ack arriving after reset is ignored.
- Back-to-back accesses: DONE → IDLE → next request. There is always at least one IDLE cycle between requests.
- The counter width is clog2(`TIMEOUT`+1) and never wraps; it is cleared on entry to WAIT.

## Timing

- Reset values: state IDLE; `mem_req` 0, `mem_wr` 0, `mem_addr` 0, `mem_wdata` 0, `MEM_rdata` 0, `MEM_rdata_valid` 0, `err_pulse` 0, `err_sticky` 0, counter 0. `Stall_DM` = `access` (combinational from IDLE).
- Access first seen in cycle 0 (IDLE, `Stall_DM`=1). `mem_req` rises in cycle 1.
- Ack in cycle 1+k. DONE in cycle 2+k, where `MEM_rdata_valid`=1 and `Stall_DM`=0. EXMEM advances at the end of cycle 2+k.
- Minimum latency is 3 cycles, with 2 stall cycles.
- Timeout: DONE in cycle 1+`TIMEOUT`.
- Misaligned access: DONE in cycle 1, with 1 stall cycle.

## Structure

- Shared package `dmem_pkg`:
  - state encoding IDLE=2'b00, WAIT=2'b01, DONE=2'b10;
  - `DMEM_TIMEOUT_DEFAULT`=16.
- Address and write-data holding registers reuse the existing `register16` (WIDTH=16), enabled on the IDLE→WAIT transition.
- No other sub-module is needed.

## Test plan

- Load, addr 0x0010, memory acks 3 cycles after `mem_req` rises with `mem_rdata`=0xBEEF → `Stall_DM` high for 4 cycles; `MEM_rdata`=0xBEEF with `MEM_rdata_valid` for 1 cycle; `mem_req` high for exactly 3 cycles.
- Store, addr 0x0020, data 0x1234, immediate ack → `mem_wr`=1, `mem_addr`=0x0020, `mem_wdata`=0x1234; 2 stall cycles; `MEM_rdata_valid` stays 0.
- Load to addr 0x0021 → no `mem_req`; 1 stall cycle; `err_pulse` in the next cycle; `err_sticky`=1 until `rst`.
- `TIMEOUT`=4, memory never acks → `mem_req` high for 4 cycles; `err_pulse` in cycle 5; stall released; a late ack is ignored.
- `rst` asserted in the second WAIT cycle → `mem_req`=0 and state IDLE next cycle; a subsequent ack produces no `MEM_rdata_valid`; all outputs at reset values.
- Two back-to-back loads (0x0002→0x1111, 0x0004→0x2222), ack after 1 cycle each → two distinct `MEM_rdata_valid` pulses in order; exactly one IDLE cycle between requests; no duplicate request.
